// File: rtl/nl2_scrub_pkg.sv
// Shared types and parameter-legality helpers for the dbank scrub queue.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
`ifndef nl2_SRAM_BLOCK_ADDR_SIZE
`define nl2_SRAM_BLOCK_ADDR_SIZE 10
`endif

package nl2_scrub_pkg;

    // Widest configuration the entry storage is sized for. Narrower
    // instances zero-extend into these fields; the constant upper bits
    // fold away in synthesis.
    localparam int SCRUB_MAX_N_SRAM = 8;
    localparam int SCRUB_MAX_ADDR   = 32;

    // Legal values for both N_SRAM and DEPTH.
    localparam int SCRUB_LEGAL_A = 2;
    localparam int SCRUB_LEGAL_B = 4;
    localparam int SCRUB_LEGAL_C = 8;

    typedef struct packed {
        logic [SCRUB_MAX_N_SRAM-1:0] bnk;
        logic [SCRUB_MAX_ADDR-1:0]   addr;
    } scrub_entry_t;

    function automatic logic legal_size(input int v);
        return (v == SCRUB_LEGAL_A) || (v == SCRUB_LEGAL_B) || (v == SCRUB_LEGAL_C);
    endfunction

    // Exactly one bit set.
    function automatic logic is_onehot(input logic [SCRUB_MAX_N_SRAM-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/nl2_scrub_fifo.sv
// Pointer-based FIFO holding scrub entries, with full/empty/count status.
// Latency: a write is visible at rd_dat the cycle after it is written; no bypass.
// Backpressure: none internally; the caller must not write when full unless reading in the same cycle.
//
// Ports: clk, rst_a (async active-low); wr_en/wr_dat push; rd_en pops head;
//        rd_dat head entry; full, empty, count status.
module nl2_scrub_fifo
    import nl2_scrub_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             wr_en,
    input  scrub_entry_t     wr_dat,
    input  logic             rd_en,
    output scrub_entry_t     rd_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    scrub_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage carries no reset: entries are only observable through count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_dat = mem[rptr];
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/nl2_new_dbank_scrub_queue.sv
// Scrub command queue for dbanks: external commands plus a background address sweep, issued in FIFO order.
// Latency: push visible at head next cycle; head issues combinationally once its bank is active next cycle and data is held.
// Backpressure: req_ack drops when the queue is full unless the head issues in the same cycle.
//
// Ports: clk, rst_a (async active-low); req_scrub/req_bnk/req_addr command in,
//        req_ack accept; req_data_rcv and dbank_active_next gate issue; sweep_en
//        enables the background sweep; scrub_pending/scrub_proc/scrub_bnk/
//        scrub_addr/q_count describe the head and occupancy; sweep_done and
//        err_bnk are one-cycle status pulses.
module nl2_new_dbank_scrub_queue
    import nl2_scrub_pkg::*;
#(
    parameter int N_SRAM          = 4,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE,
    parameter int DEPTH           = 4
) (
    input  logic                         clk,
    input  logic                         rst_a,
    input  logic                         req_scrub,
    output logic                         req_ack,
    input  logic [N_SRAM-1:0]            req_bnk,
    input  logic [BLOCK_ADDR_SIZE-1:0]   req_addr,
    input  logic                         req_data_rcv,
    input  logic [N_SRAM-1:0]            dbank_active_next,
    input  logic                         sweep_en,
    output logic                         scrub_pending,
    output logic                         scrub_proc,
    output logic [N_SRAM-1:0]            scrub_bnk,
    output logic [BLOCK_ADDR_SIZE-1:0]   scrub_addr,
    output logic [$clog2(DEPTH+1)-1:0]   q_count,
    output logic                         sweep_done,
    output logic                         err_bnk
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (!legal_size(N_SRAM)) begin : g_bad_n_sram
        $error("nl2_new_dbank_scrub_queue: N_SRAM must be 2, 4 or 8");
    end
    if (!legal_size(DEPTH)) begin : g_bad_depth
        $error("nl2_new_dbank_scrub_queue: DEPTH must be 2, 4 or 8");
    end
    if (BLOCK_ADDR_SIZE < 1 || BLOCK_ADDR_SIZE > SCRUB_MAX_ADDR) begin : g_bad_addr
        $error("nl2_new_dbank_scrub_queue: BLOCK_ADDR_SIZE out of range");
    end

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;
    scrub_entry_t               head;
    scrub_entry_t               push_ent;
    logic [N_SRAM-1:0]          head_bnk;
    logic [BLOCK_ADDR_SIZE-1:0] head_addr;
    logic                       head_hi_unused;

    logic [N_SRAM-1:0]          sweep_bnk;
    logic [BLOCK_ADDR_SIZE-1:0] sweep_addr;
    logic                       sweep_wrap;

    logic                       bnk_ok;
    logic                       ext_push;
    logic                       inject;
    logic                       push;

    assign head_bnk  = head.bnk[N_SRAM-1:0];
    assign head_addr = head.addr[BLOCK_ADDR_SIZE-1:0];
    // Zero-extension bits of the shared entry type carry no information.
    assign head_hi_unused = |(head.bnk >> N_SRAM) | |(head.addr >> BLOCK_ADDR_SIZE);

    // Issue when the head's bank will be active and its write data is ready.
    assign scrub_proc = ~fifo_empty & req_data_rcv & |(head_bnk & dbank_active_next);

    // A full queue can still accept because the issuing head frees a slot at
    // the same edge. Gating with rst_a keeps the handshake quiet in reset.
    assign req_ack = rst_a & req_scrub & (~fifo_full | scrub_proc);

    // Malformed bank selects are acknowledged so the requester is not stuck,
    // but they never enter the queue.
    assign bnk_ok   = is_onehot(SCRUB_MAX_N_SRAM'(req_bnk));
    assign ext_push = req_ack & bnk_ok;

    // The sweep only fills an idle queue and always yields to a requester.
    assign inject = sweep_en & fifo_empty & ~req_scrub;
    assign push   = ext_push | inject;

    assign sweep_wrap = &sweep_addr;

    always_comb begin
        push_ent = '0;
        if (req_scrub) begin
            push_ent.bnk  = SCRUB_MAX_N_SRAM'(req_bnk);
            push_ent.addr = SCRUB_MAX_ADDR'(req_addr);
        end else begin
            push_ent.bnk  = SCRUB_MAX_N_SRAM'(sweep_bnk);
            push_ent.addr = SCRUB_MAX_ADDR'(sweep_addr);
        end
    end

    nl2_scrub_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .rst_a  (rst_a),
        .wr_en  (push),
        .wr_dat (push_ent),
        .rd_en  (scrub_proc),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Sweep position only advances on an actual inject, so dropping sweep_en
    // freezes it in place. Rotating the MSB bank left lands back on bit0,
    // which is exactly the restart point after a full sweep.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            sweep_bnk  <= {{(N_SRAM-1){1'b0}}, 1'b1};
            sweep_addr <= '0;
            sweep_done <= 1'b0;
            err_bnk    <= 1'b0;
        end else begin
            sweep_done <= inject & sweep_wrap & sweep_bnk[N_SRAM-1];
            err_bnk    <= req_ack & ~bnk_ok;
            if (inject) begin
                sweep_addr <= sweep_addr + 1'b1;
                if (sweep_wrap) begin
                    sweep_bnk <= {sweep_bnk[N_SRAM-2:0], sweep_bnk[N_SRAM-1]};
                end
            end
        end
    end

    assign scrub_pending = ~fifo_empty;
    assign scrub_bnk     = fifo_empty ? '0 : head_bnk;
    assign scrub_addr    = fifo_empty ? '0 : head_addr;
    assign q_count       = fifo_count;

endmodule

// File: doc/nl2_new_dbank_scrub_queue.md
NL2_NEW_DBANK_SCRUB_QUEUE -- requirements
Module: nl2_new_dbank_scrub_queue

Interface
REQ-001 Parameter N_SRAM, default 4, number of dbanks; legal values {2,4,8}.
REQ-002 Parameter BLOCK_ADDR_SIZE, default `nl2_SRAM_BLOCK_ADDR_SIZE, bank address width.
REQ-003 Parameter DEPTH, default 4, command queue entries; legal values {2,4,8}.
REQ-004 Clock and reset: one clock, clk; reset rst_a is asynchronous and active-low.
REQ-005 clk  in  1  block clock.
REQ-006 rst_a  in  1  asynchronous active-low reset.
REQ-007 req_scrub  in  1  external scrub command valid.
REQ-008 req_ack  out  1  command accepted this cycle.
REQ-009 req_bnk  in  N_SRAM  one-hot bank select.
REQ-010 req_addr  in  BLOCK_ADDR_SIZE  bank address.
REQ-011 req_data_rcv  in  1  write-data register holds scrub data.
REQ-012 dbank_active_next  in  N_SRAM  next-cycle active dbanks.
REQ-013 sweep_en  in  1  enable background address sweep.
REQ-014 scrub_pending  out  1  queue non-empty.
REQ-015 scrub_proc  out  1  head entry issued this cycle (1-cycle pulse).
REQ-016 scrub_bnk  out  N_SRAM  head bank; 0 when empty.
REQ-017 scrub_addr  out  BLOCK_ADDR_SIZE  head address; 0 when empty.
REQ-018 q_count  out  $clog2(DEPTH+1)  current occupancy.
REQ-019 sweep_done  out  1  1-cycle pulse when a full sweep over all banks is enqueued.
REQ-020 err_bnk  out  1  1-cycle pulse: accepted req_bnk not one-hot.

Function
REQ-021 Queue is FIFO of {bnk, addr}; issue strictly in enqueue order.
REQ-022 scrub_proc = non-empty & req_data_rcv & |(head_bnk & dbank_active_next), combinational.
REQ-023 scrub_proc pops head at the same clock edge.
REQ-024 req_ack = req_scrub & (not full | scrub_proc), combinational; push on req_ack.
REQ-025 Simultaneous push and pop when full: count unchanged, new entry at tail.
REQ-026 Push into empty queue: entry visible at head the next cycle; no same-cycle bypass.
REQ-027 req_bnk not one-hot when accepted: req_ack asserted, entry discarded, err_bnk pulsed next cycle.
REQ-028 Sweep generator holds sweep_bnk (one-hot, reset bit0) and sweep_addr (reset 0).
REQ-029 Sweep inject: when sweep_en & queue empty & ~req_scrub, push {sweep_bnk, sweep_addr}; external requests always take priority.
REQ-030 After each inject: sweep_addr increments; on wrap from all-ones to 0, sweep_bnk rotates left by one.
REQ-031 Inject with sweep_addr all-ones and sweep_bnk MSB set: sweep_done pulses next cycle; generator returns to bit0/0.
REQ-032 sweep_en deassertion freezes generator position; reassertion resumes from it.
REQ-033 q_count increments on push only, decrements on pop only, unchanged on both or neither; never exceeds DEPTH.

Reset
REQ-034 On rst_a low: queue empty, pointers 0, q_count 0, sweep generator at bit0/addr 0.
REQ-035 During and after reset: req_ack, scrub_proc, scrub_pending, sweep_done, err_bnk are 0; scrub_bnk and scrub_addr are 0.
REQ-036 Reset mid-operation discards all queued entries; no scrub_proc in the cycle after release.

Structure
REQ-037 Shared package nl2_scrub_pkg holds the entry struct type {bnk, addr} and the DEPTH/N_SRAM legality constants.
REQ-038 One sub-module, nl2_scrub_fifo (DEPTH-entry, pointer-based, full/empty/count outputs), is instantiated for storage.
REQ-039 Parameter legality is checked by elaboration-time assertions.

Verification
REQ-040 Single cmd: req_bnk=4'b0010, addr=0x15, data_rcv=1, active_next=4'b0010 -> ack in cycle 0, scrub_proc in cycle 1 with bnk 0010/addr 0x15, pending 0 in cycle 2.
REQ-041 Fill: 4 pushes with active_next=0 -> q_count=4; 5th req_scrub -> req_ack=0; set active_next=all -> pops in order, 5th acked on first pop cycle.
REQ-042 Bank mismatch: head bnk 0100, active_next=0001 for 10 cycles -> no scrub_proc; active_next=0100 -> one pop.
REQ-043 Bad bank: req_bnk=4'b0110 -> req_ack=1, err_bnk next cycle, q_count stays 0.
REQ-044 Sweep: BLOCK_ADDR_SIZE=2, N_SRAM=2, sweep_en=1, always issuing -> entries (01,0..3),(10,0..3), sweep_done after the 8th inject; external req mid-sweep preempts one inject.
REQ-045 Reset: rst_a low with q_count=3 -> all outputs 0 immediately; after release, no scrub_proc until a new push.
